// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Holds the program counter and picks the next PC (trap > mret > branch >
// sequential). Runs a req/ack handshake with instruction memory and drives
// the IF/ID register. A one-word skid buffer absorbs an ack that arrives
// while decode is stalled. DROP waits out a request that a redirect made stale.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned branch/mret target raises misaligned_out and parks the stage
// in IDLE until the next redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out,
    output logic        flush_out
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_out
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUF  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Clear the byte-offset bits so the address names a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        align_word = {addr[31:2], 2'b00};
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic        req_r, req_nxt_s;
    logic [31:0] skid_r, skid_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] pc_plus4_r;
    logic        valid_r, valid_nxt_s;
    logic        flush_r;
    logic        halt_r, halt_nxt_s;
    logic        redirect_s;
    logic        misalign_s;
    logic        outstanding_s;
    logic [31:0] raw_target_s;
    logic [31:0] target_s;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_r, misaligned_nxt_s;
`endif

    assign redirect_s    = trap_taken_in | mret_in | branch_taken_in;
    // A request is still open this cycle if it is being presented and not acked.
    assign outstanding_s = ((state_r == ST_REQ) || (state_r == ST_DROP)) && !imem_ack_in;

    // Redirect target selection with trap > mret > branch priority.
    always_comb begin
        raw_target_s = branch_target_in;
        if (trap_taken_in) begin
            raw_target_s = trap_addr_in;
        end else if (mret_in) begin
            raw_target_s = epc_in;
        end else begin
            raw_target_s = branch_target_in;
        end
    end

    assign target_s = align_word(raw_target_s);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap vectors are always forced aligned, so only branch/mret can misalign.
    assign misalign_s = !trap_taken_in && (raw_target_s[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, PC, skid and IF/ID update; a redirect overrides everything.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        skid_nxt_s     = skid_r;
        instr_nxt_s    = instr_r;
        pc_nxt_s       = pc_r;
        valid_nxt_s    = valid_r;
        halt_nxt_s     = halt_r;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (halt_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack_in && !stall_in) begin
                    instr_nxt_s    = imem_rdata_in;
                    pc_nxt_s       = fetch_pc_r;
                    valid_nxt_s    = 1'b1;
                    fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                end else if (imem_ack_in) begin
                    skid_nxt_s     = imem_rdata_in;
                    fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                    state_nxt_s    = ST_BUF;
                end else if (!stall_in) begin
                    instr_nxt_s = NOP;
                    valid_nxt_s = 1'b0;
                end else begin
                    instr_nxt_s = instr_r;
                end
            end
            ST_BUF: begin
                // fetch_pc already stepped past the buffered word.
                if (!stall_in) begin
                    instr_nxt_s = skid_r;
                    pc_nxt_s    = fetch_pc_r - 32'd4;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_BUF;
                end
            end
            ST_DROP: begin
                if (imem_ack_in) begin
                    state_nxt_s = halt_r ? ST_IDLE : ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (redirect_s) begin
            instr_nxt_s = NOP;
            valid_nxt_s = 1'b0;
            skid_nxt_s  = NOP;
            if (misalign_s) begin
                halt_nxt_s  = 1'b1;
                pc_nxt_s    = raw_target_s;
                state_nxt_s = outstanding_s ? ST_DROP : ST_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
                misaligned_nxt_s = 1'b1;
`endif
            end else begin
                halt_nxt_s     = 1'b0;
                fetch_pc_nxt_s = target_s;
                state_nxt_s    = outstanding_s ? ST_DROP : ST_REQ;
            end
        end else begin
            halt_nxt_s = halt_nxt_s;
        end
    end

    // Request address follows fetch_pc on entering/staying in REQ; held in DROP.
    always_comb begin
        if (state_nxt_s == ST_REQ) begin
            addr_nxt_s = fetch_pc_nxt_s;
        end else begin
            addr_nxt_s = addr_r;
        end
        req_nxt_s = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DROP);
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            skid_r     <= NOP;
            instr_r    <= NOP;
            pc_r       <= RESET_PC;
            pc_plus4_r <= RESET_PC + 32'd4;
            valid_r    <= 1'b0;
            flush_r    <= 1'b1;
            halt_r     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            addr_r     <= addr_nxt_s;
            req_r      <= req_nxt_s;
            skid_r     <= skid_nxt_s;
            instr_r    <= instr_nxt_s;
            pc_r       <= pc_nxt_s;
            pc_plus4_r <= pc_nxt_s + 32'd4;
            valid_r    <= valid_nxt_s;
            flush_r    <= ~valid_nxt_s;
            halt_r     <= halt_nxt_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_r <= misaligned_nxt_s;
`endif
        end
    end

    assign imem_req_out  = req_r;
    assign imem_addr_out = addr_r;
    assign instr_out     = instr_r;
    assign pc_out        = pc_r;
    assign pc_plus4_out  = pc_plus4_r;
    assign valid_out     = valid_r;
    assign flush_out     = flush_r;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned_out = misaligned_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage (RESET_PC = 0x100).
// Memory model returns addr ^ 0xA5 after a programmable number of wait states.
module tb_fetch_stage;

    logic        clk_in = 1'b0;
    logic        rst_in, stall_in;
    logic        branch_taken_in, trap_taken_in, mret_in;
    logic [31:0] branch_target_in, trap_addr_in, epc_in;
    logic        imem_req_out, imem_ack_in;
    logic [31:0] imem_addr_out, imem_rdata_in;
    logic [31:0] instr_out, pc_out, pc_plus4_out;
    logic        valid_out, flush_out;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_out;
`endif

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
        .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
        .trap_taken_in(trap_taken_in), .trap_addr_in(trap_addr_in),
        .mret_in(mret_in), .epc_in(epc_in),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_rdata_in(imem_rdata_in),
        .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .valid_out(valid_out), .flush_out(flush_out)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misaligned_out(misaligned_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Wait-state counter of the memory model; cleared on ack, idle or reset.
    always @(posedge clk_in) begin
        if (rst_in || !imem_req_out || imem_ack_in) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign imem_ack_in   = imem_req_out && (wait_cnt >= mem_wait);
    assign imem_rdata_in = imem_addr_out ^ 32'h0000_00A5;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b1; stall_in = 1'b0;
        branch_taken_in = 1'b0; branch_target_in = 32'h0;
        trap_taken_in = 1'b0; trap_addr_in = 32'h0;
        mret_in = 1'b0; epc_in = 32'h0;
        tick(); tick();
        chk("rst_instr", instr_out, 32'h13);
        chk("rst_pc", pc_out, 32'h100);
        chk("rst_pc4", pc_plus4_out, 32'h104);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_flush", {31'd0, flush_out}, 32'd1);
        chk("rst_req", {31'd0, imem_req_out}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_mis", {31'd0, misaligned_out}, 32'd0);
`endif
        rst_in = 1'b0;
        tick();
        chk("first_req", {31'd0, imem_req_out}, 32'd1);
        chk("first_addr", imem_addr_out, 32'h100);
        tick();
        chk("seq0_instr", instr_out, 32'h1A5);
        chk("seq0_pc", pc_out, 32'h100);
        chk("seq0_pc4", pc_plus4_out, 32'h104);
        chk("seq0_valid", {31'd0, valid_out}, 32'd1);
        chk("seq0_flush", {31'd0, flush_out}, 32'd0);
        tick();
        chk("seq1_instr", instr_out, 32'h1A1);
        chk("seq1_pc", pc_out, 32'h104);
        chk("seq1_addr", imem_addr_out, 32'h108);
        // stall for three cycles while 0x108 is acked
        stall_in = 1'b1;
        tick();
        chk("buf0_req", {31'd0, imem_req_out}, 32'd0);
        chk("buf0_instr", instr_out, 32'h1A1);
        chk("buf0_valid", {31'd0, valid_out}, 32'd1);
        tick();
        chk("buf1_req", {31'd0, imem_req_out}, 32'd0);
        chk("buf1_instr", instr_out, 32'h1A1);
        tick();
        chk("buf2_instr", instr_out, 32'h1A1);
        chk("buf2_pc", pc_out, 32'h104);
        stall_in = 1'b0;
        tick();
        chk("skid_instr", instr_out, 32'h1AD);
        chk("skid_pc", pc_out, 32'h108);
        chk("skid_req", {31'd0, imem_req_out}, 32'd1);
        chk("skid_addr", imem_addr_out, 32'h10C);
        // two wait states, branch one cycle after the 0x10C request
        mem_wait = 2;
        tick();
        chk("ws_bubble_valid", {31'd0, valid_out}, 32'd0);
        chk("ws_bubble_addr", imem_addr_out, 32'h10C);
        branch_taken_in = 1'b1; branch_target_in = 32'h200;
        tick();
        branch_taken_in = 1'b0;
        chk("drop_addr", imem_addr_out, 32'h10C);
        chk("drop_req", {31'd0, imem_req_out}, 32'd1);
        chk("drop_flush", {31'd0, flush_out}, 32'd1);
        tick();
        chk("br_addr", imem_addr_out, 32'h200);
        chk("br_flush0", {31'd0, flush_out}, 32'd1);
        chk("br_instr_nop", instr_out, 32'h13);
        tick(); tick();
        chk("br_flush1", {31'd0, flush_out}, 32'd1);
        tick();
        chk("br_instr", instr_out, 32'h2A5);
        chk("br_pc", pc_out, 32'h200);
        chk("br_flush2", {31'd0, flush_out}, 32'd0);
        // trap and branch together: trap wins, low bits forced to zero
        mem_wait = 0;
        trap_taken_in = 1'b1; trap_addr_in = 32'h803;
        branch_taken_in = 1'b1; branch_target_in = 32'h300;
        tick();
        trap_taken_in = 1'b0; branch_taken_in = 1'b0;
        chk("trap_addr", imem_addr_out, 32'h800);
        chk("trap_flush", {31'd0, flush_out}, 32'd1);
        chk("trap_instr_nop", instr_out, 32'h13);
        tick();
        chk("trap_instr", instr_out, 32'h8A5);
        chk("trap_pc", pc_out, 32'h800);
        chk("trap_pc4", pc_plus4_out, 32'h804);
        mret_in = 1'b1; epc_in = 32'h104;
        tick();
        mret_in = 1'b0;
        chk("mret_addr", imem_addr_out, 32'h104);
        tick();
        chk("mret_instr", instr_out, 32'h1A1);
        chk("mret_pc", pc_out, 32'h104);
        // wrap at the top of the address space
        trap_taken_in = 1'b1; trap_addr_in = 32'hFFFF_FFFC;
        tick();
        trap_taken_in = 1'b0;
        chk("wrap_addr0", imem_addr_out, 32'hFFFF_FFFC);
        tick();
        chk("wrap_instr0", instr_out, 32'hFFFF_FF59);
        chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", pc_plus4_out, 32'h0);
        chk("wrap_addr1", imem_addr_out, 32'h0);
        tick();
        chk("wrap_instr1", instr_out, 32'hA5);
        chk("wrap_pc1", pc_out, 32'h0);
        chk("wrap_pc4_1", pc_plus4_out, 32'h4);
        // branch to a misaligned target
        branch_taken_in = 1'b1; branch_target_in = 32'h202;
        tick();
        branch_taken_in = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_pulse", {31'd0, misaligned_out}, 32'd1);
        chk("mis_pc", pc_out, 32'h202);
        chk("mis_req0", {31'd0, imem_req_out}, 32'd0);
        chk("mis_valid", {31'd0, valid_out}, 32'd0);
        tick();
        chk("mis_pulse_end", {31'd0, misaligned_out}, 32'd0);
        chk("mis_req1", {31'd0, imem_req_out}, 32'd0);
        tick();
        chk("mis_req2", {31'd0, imem_req_out}, 32'd0);
        trap_taken_in = 1'b1; trap_addr_in = 32'h800;
        tick();
        trap_taken_in = 1'b0;
        chk("mis_resume_req", {31'd0, imem_req_out}, 32'd1);
        chk("mis_resume_addr", imem_addr_out, 32'h800);
        tick();
        chk("mis_resume_instr", instr_out, 32'h8A5);
`else
        chk("align_addr", imem_addr_out, 32'h200);
        chk("align_flush", {31'd0, flush_out}, 32'd1);
        tick();
        chk("align_instr", instr_out, 32'h2A5);
        chk("align_pc", pc_out, 32'h200);
`endif
        // reset while a request is waiting on memory
        mem_wait = 3;
        tick();
        rst_in = 1'b1;
        tick();
        chk("midrst_req", {31'd0, imem_req_out}, 32'd0);
        chk("midrst_pc", pc_out, 32'h100);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        chk("midrst_instr", instr_out, 32'h13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. It holds the program counter, selects the next PC among sequential, branch, trap and mret targets, and runs a request/ack handshake with instruction memory. It drives the IF/ID register whose `instr_out`/`flush_out` feed the decode stage's instruction field splitter. It absorbs memory wait states, downstream stalls and redirects that arrive while a fetch is in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `stall_in` in 1: decode cannot accept; IF/ID holds.
- `branch_taken_in` in 1, `branch_target_in` in 32: branch/jump redirect from execute.
- `trap_taken_in` in 1, `trap_addr_in` in 32: trap redirect (mtvec).
- `mret_in` in 1, `epc_in` in 32: return-from-trap redirect.
- `imem_req_out` out 1, `imem_addr_out` out 32: fetch request and word address.
- `imem_ack_in` in 1, `imem_rdata_in` in 32: request complete and data. Ack is valid in the same cycle as the request (zero-wait) or later.
- `instr_out` out 32: IF/ID instruction, to decode `instr_in`.
- `pc_out` out 32, `pc_plus4_out` out 32: PC of `instr_out` and that PC + 4.
- `valid_out` out 1: IF/ID holds a real instruction.
- `flush_out` out 1: equals `~valid_out`, registered; to decode `flush_in`.
- `misaligned_out` out 1: present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- Redirect priority: trap > mret > branch > sequential (`fetch_pc + 4`). The redirect target is always 32 bits wide. `trap_addr_in[1:0]` is forced to 00.
- Internal `fetch_pc` holds the address of the current or next request. There is a one-word skid register.
- States:
  - IDLE: `imem_req_out` = 0. Entered at reset. Goes to REQ the next cycle.
  - REQ: `imem_req_out` = 1, `imem_addr_out` = `fetch_pc`, held stable until ack.
    - ack, no stall, no redirect: IF/ID ← {rdata, `fetch_pc`}; `valid_out` = 1; `fetch_pc` += 4; stay in REQ.
    - ack with `stall_in`: skid ← rdata; `fetch_pc` += 4; go to BUF.
    - no ack, no stall: IF/ID becomes a bubble (`valid_out` = 0).
    - no ack with stall: IF/ID holds.
  - BUF: `imem_req_out` = 0; IF/ID holds. When `stall_in` = 0: IF/ID ← skid; go to REQ.
  - DROP: `imem_req_out` = 1 at the old address, which cannot be withdrawn. The acked data is discarded. On ack, go to REQ.
- Redirect in any state overrides `stall_in`:
  - `fetch_pc` ← target; IF/ID invalidated (`instr_out` = 32'h13, `valid_out` = 0); skid discarded.
  - From REQ without ack in the same cycle: go to DROP.
  - From REQ with ack, or from BUF/IDLE: go to REQ.
  - From DROP: stay in DROP with the new target.
- `pc_plus4_out` = `pc_out` + 4, mod 2^32. `fetch_pc` wraps from 0xFFFF_FFFC to 0.

## Timing
- Reset values: `instr_out` = 32'h13, `pc_out` = `RESET_PC`, `pc_plus4_out` = `RESET_PC` + 4, `valid_out` = 0, `flush_out` = 1, `imem_req_out` = 0, `misaligned_out` = 0, state IDLE.
- First request at `RESET_PC` occurs in the second cycle after `rst_in` falls.
- Reset mid-fetch abandons any outstanding request without waiting for ack. Memory is reset by the same `rst_in`.
- Zero-wait memory sustains 1 instruction/cycle. Fetch-to-`instr_out` latency is 1 cycle after ack.
- Redirect sampled in cycle N:
  - `flush_out` = 1 in N+1.
  - `imem_addr_out` = target in N+1 if no request is outstanding; otherwise in the cycle after the pending ack.
  - With zero-wait memory, target instruction appears in N+2.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A branch or mret target with `[1:0]` ≠ 00 issues no fetch.
  - `misaligned_out` pulses for 1 cycle in N+1, with `pc_out` = the bad target.
  - State goes to IDLE and stays there until the next redirect (the expected trap).
- Undefined: the port is absent and target bits `[1:0]` are forced to 00.

## Test plan
- Reset, `RESET_PC` = 0x100, zero-wait memory returning addr^0xA5 → `instr_out` sequence for PCs 0x100, 0x104, 0x108 on consecutive cycles; `flush_out` = 0 from the first valid instruction.
- `stall_in` high 3 cycles while ack arrives for 0x108 → IF/ID holds 0x104, skid captures 0x108, `imem_req_out` = 0 during BUF; 0x108 appears the cycle stall drops, with no duplicates or gaps.
- Memory with 2 wait states, branch to 0x200 one cycle after the request for 0x10C → request for 0x10C held to its ack, data dropped, next request 0x200; `flush_out` = 1 until 0x200 is valid.
- `trap_taken_in` (0x800) and `branch_taken_in` (0x300) in the same cycle → next fetch at 0x800. Then `mret_in` with `epc_in` = 0x104 → fetch at 0x104.
- Wrap: `fetch_pc` = 0xFFFF_FFFC → next request 0x0; `pc_plus4_out` = 0x0.
- With `FETCH_MISALIGN_TRAP_EN`, branch to 0x202 → `misaligned_out` = 1 for 1 cycle with `pc_out` = 0x202, no request issued; a trap to 0x800 resumes fetching.
